sdr_16_port_arbiter: RTL

Shares the single 16-bit SDR SDRAM command FSM between `nr_of_ports` ingress FIFOs and generates its periodic auto-refresh request. It sits between the per-port ingress FIFOs and the SDR FSM, all in the `sdram_clk` domain. It picks a port round-robin whenever the FSM is idle and holds that grant for the whole access. It routes the FSM's `fifo_rd` and `fifo_empty` to and from the granted port.

---
 rtl/sdr_16_port_arbiter_pkg.sv | 29 ++
 rtl/sdr_16_port_arbiter_rr_pick.sv | 36 +++
 rtl/sdr_16_port_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/sdr_16_port_arbiter_pkg.sv
// Shared SDR controller definitions: refresh defaults plus the SDR command
// and burst-type encodings used across the SDRAM datapath.
package sdr_16_port_arbiter_pkg;

   localparam int RFR_LENGTH_DEFAULT     = 390;
   localparam int RFR_WRAP_WIDTH_DEFAULT = 9;
   localparam int SDRAM_CLK_MHZ          = 50;
   localparam int RFR_INTERVAL_NS        = 7800;

   // {ras_n, cas_n, we_n}
   typedef enum logic [2:0] {
      CMD_NOP  = 3'b111,
      CMD_ACT  = 3'b011,
      CMD_RD   = 3'b101,
      CMD_WR   = 3'b100,
      CMD_BST  = 3'b110,
      CMD_PRE  = 3'b010,
      CMD_AREF = 3'b001,
      CMD_LMR  = 3'b000
   } sdr_cmd_e;

   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

endpackage

// File: rtl/sdr_16_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester above the previous grant,
// wrapping; returns the previous grant when nobody requests.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_req,
   input  logic [N-1:0] i_prev,
   output logic [N-1:0] o_grant
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   int unsigned     w_prev_idx;
   logic [IW-1:0]   w_idx;
   logic            w_found;

   always_comb begin
      w_prev_idx = 0;
      w_idx      = '0;
      w_found    = 1'b0;
      o_grant    = i_prev;
      for (int unsigned p = 0; p < N; p++) begin
         if (i_prev[p]) w_prev_idx = p;
      end
      // offset N lands back on the previous grant, so it has lowest priority
      for (int unsigned off = 1; off <= N; off++) begin
         w_idx = IW'((w_prev_idx + off) % N);
         if (!w_found && i_req[w_idx]) begin
            o_grant = '0;
            o_grant[w_idx] = 1'b1;
            w_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdr_16_port_arbiter.sv
// Shares the SDR command FSM between ingress FIFOs (round-robin, held for a
// whole access) and generates the periodic auto-refresh request.
module sdr_16_port_arbiter
   import sdr_16_port_arbiter_pkg::*;
#(
   parameter int nr_of_ports    = 4,
   parameter int rfr_length     = RFR_LENGTH_DEFAULT,
   parameter int rfr_wrap_width = RFR_WRAP_WIDTH_DEFAULT
) (
   input  logic                   sdram_clk,
   input  logic                   sdram_rst,
   input  logic [nr_of_ports-1:0] fifo_empty_i,
   output logic [nr_of_ports-1:0] fifo_rd_o,
   output logic [nr_of_ports-1:0] fifo_sel_o,
   input  logic                   state_idle_i,
   input  logic                   fifo_rd_i,
   output logic                   fifo_empty_o,
   input  logic                   cmd_aref_i,
   output logic                   refresh_req_o,
   output logic                   rfr_missed_o
);

   localparam logic [rfr_wrap_width-1:0] RFR_RELOAD = rfr_wrap_width'(rfr_length - 1);
   localparam logic [nr_of_ports-1:0]    SEL_RST    = {1'b1, {(nr_of_ports-1){1'b0}}};

   logic [rfr_wrap_width-1:0] r_rfr_cnt;
   logic                      r_refresh_req;
   logic                      r_rfr_missed;
   logic [nr_of_ports-1:0]    r_sel;
   logic [nr_of_ports-1:0]    w_next_sel;
   logic [nr_of_ports-1:0]    w_req_vec;
   logic                      w_expire;
   logic                      w_arb_en;

   assign w_expire = (r_rfr_cnt == '0);

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         r_rfr_cnt     <= RFR_RELOAD;
         r_refresh_req <= 1'b0;
         r_rfr_missed  <= 1'b0;
      end else begin
         r_rfr_cnt <= w_expire ? RFR_RELOAD : r_rfr_cnt - 1'b1;
         if (w_expire)
            r_refresh_req <= 1'b1;
         else if (cmd_aref_i)
            r_refresh_req <= 1'b0;
         // a request being acknowledged on the expiry cycle was not missed
         if (w_expire && r_refresh_req && !cmd_aref_i)
            r_rfr_missed <= 1'b1;
      end
   end

   assign w_req_vec = ~fifo_empty_i;
   assign w_arb_en  = state_idle_i && !r_refresh_req && (|w_req_vec);

   rr_pick #(
      .N(nr_of_ports)
   ) u_rr_pick (
      .i_req  (w_req_vec),
      .i_prev (r_sel),
      .o_grant(w_next_sel)
   );

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst)
         r_sel <= SEL_RST;
      else if (w_arb_en)
         r_sel <= w_next_sel;
   end

   assign fifo_sel_o    = r_sel;
   assign fifo_rd_o     = r_sel & {nr_of_ports{fifo_rd_i}};
   assign fifo_empty_o  = state_idle_i ? (&fifo_empty_i) : (|(r_sel & fifo_empty_i));
   assign refresh_req_o = r_refresh_req;
   assign rfr_missed_o  = r_rfr_missed;

endmodule
